// File: rtl/pipe_scoreboard.sv
// Hazard, forwarding and flush controller for the pipelined WISC core.
// In-flight register writes live in a DEPTH-slot shift table (slot 0 = EX, slot DEPTH-1 = WB).
module pipe_scoreboard #(
    parameter int AW      = 4,
    parameter int DEPTH   = 3,
    parameter int FWD_EN  = 1,
    parameter int R0_ZERO = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [AW-1:0]    id_src1,
    input  logic             id_src1_used,
    input  logic [AW-1:0]    id_src2,
    input  logic             id_src2_used,
    input  logic [AW-1:0]    id_dst,
    input  logic             id_wr_en,
    input  logic             id_is_load,
    input  logic             id_halt,
    input  logic             ex_redirect,
    output logic             stall,
    output logic             flush,
    output logic [3:0]       fwd_a,
    output logic [3:0]       fwd_b,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);
    // Valid and halt flags must reach the WB slot; dst/wr only matter in slots that
    // can hazard (0..DEPTH-2), and the load flag only matters in slot 0 (load-use).
    logic [DEPTH-1:0] v_reg;
    logic [DEPTH-1:0] hlt_reg;
    logic [DEPTH-2:0] wr_reg;
    logic [AW-1:0]    dst_reg [DEPTH-1];
    logic             ld0_reg;
    logic             halt_pend_reg;
    logic             halted_reg;
    logic [CNT_W-1:0] stall_cnt_reg;

    logic [DEPTH-2:0] match_a;
    logic [DEPTH-2:0] match_b;
    logic             src1_zero;
    logic             src2_zero;
    logic [3:0]       sel_a;
    logic [3:0]       sel_b;
    logic             hazard;
    logic             stall_int;
    logic             issue;

    assign src1_zero = (R0_ZERO != 0) && (id_src1 == '0);
    assign src2_zero = (R0_ZERO != 0) && (id_src2 == '0);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH - 1; gi++) begin : g_match
            assign match_a[gi] = id_src1_used & v_reg[gi] & wr_reg[gi]
                               & (dst_reg[gi] == id_src1) & ~src1_zero;
            assign match_b[gi] = id_src2_used & v_reg[gi] & wr_reg[gi]
                               & (dst_reg[gi] == id_src2) & ~src2_zero;
        end
    endgenerate

    // Youngest matching slot wins: scan oldest to youngest so the lowest k overwrites.
    always_comb begin
        sel_a = 4'd0;
        sel_b = 4'd0;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            if (match_a[k]) sel_a = 4'(k + 1);
            if (match_b[k]) sel_b = 4'(k + 1);
        end
    end

    always_comb begin
        if (FWD_EN != 0) hazard = (match_a[0] | match_b[0]) & ld0_reg;
        else             hazard = |{match_a, match_b};
    end

    assign flush     = ex_redirect;
    assign stall_int = (hazard | halt_pend_reg) & ~ex_redirect & ~rst;
    assign stall     = stall_int;
    assign issue     = id_valid & ~stall_int & ~ex_redirect & ~halt_pend_reg;
    assign fwd_a     = (FWD_EN != 0 && !stall_int && !ex_redirect && !rst) ? sel_a : 4'd0;
    assign fwd_b     = (FWD_EN != 0 && !stall_int && !ex_redirect && !rst) ? sel_b : 4'd0;
    assign halted    = halted_reg;
    assign stall_cnt = stall_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_reg   <= '0;
            hlt_reg <= '0;
            wr_reg  <= '0;
            ld0_reg <= 1'b0;
            for (int k = 0; k < DEPTH - 1; k++) dst_reg[k] <= '0;
        end else begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                v_reg[k]   <= v_reg[k-1];
                hlt_reg[k] <= hlt_reg[k-1];
            end
            for (int k = DEPTH - 2; k > 0; k--) begin
                wr_reg[k]  <= wr_reg[k-1];
                dst_reg[k] <= dst_reg[k-1];
            end
            v_reg[0]   <= issue;
            hlt_reg[0] <= issue & id_halt;
            wr_reg[0]  <= issue & id_wr_en;
            dst_reg[0] <= issue ? id_dst : '0;
            ld0_reg    <= issue & id_is_load;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halt_pend_reg <= 1'b0;
            halted_reg    <= 1'b0;
            stall_cnt_reg <= '0;
        end else begin
            if (issue && id_halt) halt_pend_reg <= 1'b1;
            if (v_reg[DEPTH-1] && hlt_reg[DEPTH-1]) halted_reg <= 1'b1;
            // Halt-drain stalls are not hazards, so they are left out of the count.
            if (stall_int && !halt_pend_reg && stall_cnt_reg != '1)
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_pipe_scoreboard.sv
// Scoreboard bench for pipe_scoreboard: three configurations share one ID stream and
// are checked every cycle against a cycle-age reference model of in-flight writers.
`timescale 1ns/1ps
module tb_pipe_scoreboard;
    localparam int NC = 3;
    // Configurations: 0 = forwarding/D3/R0 zero, 1 = stall-only/D3, 2 = forwarding/D5/real R0/3-bit counter
    localparam int DEP  [NC] = '{3, 3, 5};
    localparam int FWD  [NC] = '{1, 0, 1};
    localparam int R0Z  [NC] = '{1, 1, 0};
    localparam int CMAX [NC] = '{65535, 65535, 7};

    typedef struct packed {
        logic        stall;
        logic        flush;
        logic        halted;
        logic [3:0]  fa;
        logic [3:0]  fb;
        logic [15:0] cnt;
    } exp_t;
    typedef exp_t [NC-1:0] txn_t;

    typedef struct packed {
        logic       v;
        logic [3:0] dst;
        logic       wr;
        logic       ld;
        logic       hlt;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       id_valid = 1'b0, id_src1_used = 1'b0, id_src2_used = 1'b0;
    logic       id_wr_en = 1'b0, id_is_load = 1'b0, id_halt = 1'b0, ex_redirect = 1'b0;
    logic [3:0] id_src1 = '0, id_src2 = '0, id_dst = '0;

    logic        stall_o  [NC];
    logic        flush_o  [NC];
    logic        halted_o [NC];
    logic [3:0]  fwd_a_o  [NC];
    logic [3:0]  fwd_b_o  [NC];
    logic [15:0] cnt0, cnt1;
    logic [2:0]  cnt2;

    pipe_scoreboard #(.AW(4), .DEPTH(3), .FWD_EN(1), .R0_ZERO(1), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_src1(id_src1), .id_src1_used(id_src1_used),
        .id_src2(id_src2), .id_src2_used(id_src2_used),
        .id_dst(id_dst), .id_wr_en(id_wr_en), .id_is_load(id_is_load),
        .id_halt(id_halt), .ex_redirect(ex_redirect),
        .stall(stall_o[0]), .flush(flush_o[0]), .fwd_a(fwd_a_o[0]), .fwd_b(fwd_b_o[0]),
        .halted(halted_o[0]), .stall_cnt(cnt0));

    pipe_scoreboard #(.AW(4), .DEPTH(3), .FWD_EN(0), .R0_ZERO(1), .CNT_W(16)) u_b (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_src1(id_src1), .id_src1_used(id_src1_used),
        .id_src2(id_src2), .id_src2_used(id_src2_used),
        .id_dst(id_dst), .id_wr_en(id_wr_en), .id_is_load(id_is_load),
        .id_halt(id_halt), .ex_redirect(ex_redirect),
        .stall(stall_o[1]), .flush(flush_o[1]), .fwd_a(fwd_a_o[1]), .fwd_b(fwd_b_o[1]),
        .halted(halted_o[1]), .stall_cnt(cnt1));

    pipe_scoreboard #(.AW(4), .DEPTH(5), .FWD_EN(1), .R0_ZERO(0), .CNT_W(3)) u_c (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_src1(id_src1), .id_src1_used(id_src1_used),
        .id_src2(id_src2), .id_src2_used(id_src2_used),
        .id_dst(id_dst), .id_wr_en(id_wr_en), .id_is_load(id_is_load),
        .id_halt(id_halt), .ex_redirect(ex_redirect),
        .stall(stall_o[2]), .flush(flush_o[2]), .fwd_a(fwd_a_o[2]), .fwd_b(fwd_b_o[2]),
        .halted(halted_o[2]), .stall_cnt(cnt2));

    int   tests  = 0;
    int   failed = 0;
    txn_t sb_q[$];

    // Reference model: hist[c][age] is the instruction issued age+1 cycles ago (or a bubble).
    ent_t hist     [NC][8];
    logic m_hp     [NC];
    logic m_halted [NC];
    int   m_cnt    [NC];

    function automatic void clear_model(input int c);
        for (int k = 0; k < 8; k++) hist[c][k] = '0;
        m_hp[c]     = 1'b0;
        m_halted[c] = 1'b0;
        m_cnt[c]    = 0;
    endfunction

    // Age of the most recent writer of s that has not yet reached write-back, or -1.
    function automatic int youngest(input int c, input logic [3:0] s, input logic used);
        int r;
        r = -1;
        if (used && !(R0Z[c] != 0 && s == 4'd0))
            for (int k = DEP[c] - 2; k >= 0; k--)
                if (hist[c][k].v && hist[c][k].wr && hist[c][k].dst == s) r = k;
        return r;
    endfunction

    task automatic drive_cycle(input logic v, input logic [3:0] s1, input logic u1,
                               input logic [3:0] s2, input logic u2, input logic [3:0] d,
                               input logic wr, input logic ld, input logic hlt,
                               input logic redir, input logic r, output logic any_st);
        txn_t t;
        ent_t e;
        int   ka, kb;
        logic haz, st, iss;
        @(posedge clk);
        #1;
        rst = r; id_valid = v; id_src1 = s1; id_src1_used = u1; id_src2 = s2;
        id_src2_used = u2; id_dst = d; id_wr_en = wr; id_is_load = ld;
        id_halt = hlt; ex_redirect = redir;
        any_st = 1'b0;
        for (int c = 0; c < NC; c++) begin
            if (r) clear_model(c);
            ka = youngest(c, s1, u1);
            kb = youngest(c, s2, u2);
            if (FWD[c] != 0) haz = (ka == 0 || kb == 0) && hist[c][0].ld;
            else             haz = (ka >= 0) || (kb >= 0);
            st = !redir && !r && (m_hp[c] || haz);
            t[c].stall  = st;
            t[c].flush  = redir;
            t[c].halted = m_halted[c];
            t[c].fa     = (FWD[c] != 0 && !st && !redir && !r && ka >= 0) ? 4'(ka + 1) : 4'd0;
            t[c].fb     = (FWD[c] != 0 && !st && !redir && !r && kb >= 0) ? 4'(kb + 1) : 4'd0;
            t[c].cnt    = 16'(m_cnt[c]);
            any_st      = any_st | st;
            if (!r) begin
                iss = v && !st && !redir && !m_hp[c];
                if (hist[c][DEP[c]-1].v && hist[c][DEP[c]-1].hlt) m_halted[c] = 1'b1;
                if (st && !m_hp[c] && m_cnt[c] < CMAX[c]) m_cnt[c] = m_cnt[c] + 1;
                for (int k = DEP[c] - 1; k > 0; k--) hist[c][k] = hist[c][k-1];
                e.v = 1'b1; e.dst = d; e.wr = wr; e.ld = ld; e.hlt = hlt;
                hist[c][0] = iss ? e : '0;
                if (iss && hlt) m_hp[c] = 1'b1;
            end
        end
        sb_q.push_back(t);
    endtask

    // Present an instruction and hold it while any configuration stalls it.
    task automatic issue_inst(input logic v, input logic [3:0] s1, input logic u1,
                              input logic [3:0] s2, input logic u2, input logic [3:0] d,
                              input logic wr, input logic ld, input logic hlt, input logic redir);
        logic st;
        for (int i = 0; i < 6; i++) begin
            drive_cycle(v, s1, u1, s2, u2, d, wr, ld, hlt, redir, 1'b0, st);
            if (!st) break;
        end
    endtask

    task automatic nop(input int n, input logic r);
        logic st;
        for (int i = 0; i < n; i++)
            drive_cycle(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, r, st);
    endtask

    task automatic rand_inst(input int halt_pct);
        logic v, ld, wr;
        v  = ($urandom_range(0, 9) < 8);
        ld = ($urandom_range(0, 9) < 3);
        wr = ld || ($urandom_range(0, 3) != 0);
        issue_inst(v, 4'($urandom_range(0, 3)), v & 1'($urandom_range(0, 1)),
                   4'($urandom_range(0, 3)), v & 1'($urandom_range(0, 1)),
                   4'($urandom_range(0, 3)), wr, ld,
                   ($urandom_range(0, 99) < halt_pct), ($urandom_range(0, 9) == 0));
    endtask

    function automatic exp_t actual(input int c);
        exp_t a;
        a.stall  = stall_o[c];
        a.flush  = flush_o[c];
        a.halted = halted_o[c];
        a.fa     = fwd_a_o[c];
        a.fb     = fwd_b_o[c];
        case (c)
            0:       a.cnt = cnt0;
            1:       a.cnt = cnt1;
            default: a.cnt = {13'd0, cnt2};
        endcase
        return a;
    endfunction

    // Monitor: one scoreboard entry per cycle, compared mid-cycle for every configuration.
    int cyc = 0;
    always @(negedge clk) begin
        txn_t t;
        exp_t a;
        if (sb_q.size() == 0) begin
            if (cyc > 0) begin
                tests++;
                failed++;
                $display("FAIL sb_underflow cyc%0d: got no expected entry, required one", cyc);
            end
        end else begin
            t = sb_q.pop_front();
            for (int c = 0; c < NC; c++) begin
                a = actual(c);
                tests++;
                if (a !== t[c]) begin
                    failed++;
                    $display("FAIL cyc%0d cfg%0d: got st=%0b fl=%0b hl=%0b fa=%0d fb=%0d cnt=%0d, required st=%0b fl=%0b hl=%0b fa=%0d fb=%0d cnt=%0d",
                             cyc, c, a.stall, a.flush, a.halted, a.fa, a.fb, a.cnt,
                             t[c].stall, t[c].flush, t[c].halted, t[c].fa, t[c].fb, t[c].cnt);
                end
            end
            $display("[TB] cyc %0d rst=%0b v=%0b s1=%0d/%0b s2=%0d/%0b redir=%0b | A st=%0b fa=%0d fb=%0d hl=%0b cnt=%0d | B st=%0b cnt=%0d | C st=%0b fa=%0d fb=%0d cnt=%0d",
                     cyc, rst, id_valid, id_src1, id_src1_used, id_src2, id_src2_used, ex_redirect,
                     t[0].stall, t[0].fa, t[0].fb, t[0].halted, t[0].cnt,
                     t[1].stall, t[1].cnt, t[2].stall, t[2].fa, t[2].fb, t[2].cnt);
        end
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of stimulus by 200000ns, required earlier finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic st;
        for (int c = 0; c < NC; c++) clear_model(c);
        nop(2, 1'b1);
        nop(1, 1'b0);
        // Back-to-back, one-gap and two-gap RAW on R1
        issue_inst(1, 4'd5, 1, 4'd6, 1, 4'd1, 1, 0, 0, 0);
        issue_inst(1, 4'd1, 1, 4'd1, 1, 4'd2, 1, 0, 0, 0);
        nop(4, 1'b0);
        issue_inst(1, 4'd5, 1, 4'd6, 1, 4'd1, 1, 0, 0, 0);
        nop(1, 1'b0);
        issue_inst(1, 4'd1, 1, 4'd1, 1, 4'd2, 1, 0, 0, 0);
        nop(4, 1'b0);
        issue_inst(1, 4'd5, 1, 4'd6, 1, 4'd1, 1, 0, 0, 0);
        nop(2, 1'b0);
        issue_inst(1, 4'd1, 1, 4'd1, 1, 4'd2, 1, 0, 0, 0);
        nop(4, 1'b0);
        // Load-use into store data
        issue_inst(1, 4'd5, 1, 4'd0, 0, 4'd3, 1, 1, 0, 0);
        issue_inst(1, 4'd6, 1, 4'd3, 1, 4'd0, 0, 0, 0, 0);
        nop(4, 1'b0);
        // Stall-only dependency ADD R1 ; SUB R4,R1,R5
        issue_inst(1, 4'd6, 1, 4'd7, 1, 4'd1, 1, 0, 0, 0);
        issue_inst(1, 4'd1, 1, 4'd5, 1, 4'd4, 1, 0, 0, 0);
        nop(4, 1'b0);
        // Redirect while a load-use is pending
        issue_inst(1, 4'd5, 1, 4'd0, 0, 4'd3, 1, 1, 0, 0);
        drive_cycle(1, 4'd6, 1, 4'd3, 1, 4'd0, 0, 0, 0, 1, 0, st);
        nop(4, 1'b0);
        // Write R0 then read R0
        issue_inst(1, 4'd5, 1, 4'd6, 1, 4'd0, 1, 0, 0, 0);
        issue_inst(1, 4'd0, 1, 4'd0, 1, 4'd2, 1, 0, 0, 0);
        nop(4, 1'b0);
        for (int i = 0; i < 250; i++) rand_inst(0);
        // Halt drained to completion, then reset
        nop(4, 1'b0);
        drive_cycle(1, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 1, 0, 0, st);
        nop(8, 1'b0);
        nop(1, 1'b1);
        nop(2, 1'b0);
        // Halt with reset asserted mid-drain
        drive_cycle(1, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 1, 0, 0, st);
        nop(1, 1'b0);
        nop(1, 1'b1);
        nop(8, 1'b0);
        for (int i = 0; i < 200; i++) begin
            if (i % 40 == 39) nop(1, 1'b1);
            else rand_inst(3);
        end
        @(negedge clk);
        #1;
        tests++;
        if (sb_q.size() != 0) begin
            failed++;
            $display("FAIL sb_drain: got %0d pending entries, required 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
